// File: rtl/fetch_sequencer.sv
// ----------------------------------------------------------------------------
// fetch_sequencer
//
// Control sequencer for instruction fetch and jump.
//
// A fetch drives PC onto the address bus, captures PC+1 into INC, holds a
// memory read for MEM_WAIT cycles, latches the instruction, and then moves
// INC back into PC. A jump moves register J into PC. Every sequence ends
// with a single DONE cycle and then returns to IDLE.
//
// Parameters
//   MEM_WAIT   cycles the memory read is held before the instruction latch
//              (legal range 1..15)
//
// Ports
//   clock      system clock, rising edge active
//   reset      synchronous, active-low reset
//   fetch_req  fetch the instruction at PC and advance PC by one
//   jump_req   transfer register J into PC (wins over fetch_req)
//   sel_pc     PC drives the address bus
//   sel_j      J drives the address bus
//   sel_inc    INC drives the address bus
//   mem_read   memory drives the data bus
//   ld_inst    instruction register load strobe
//   ld_inc     INC register load strobe
//   ld_pc      PC load strobe from the address bus
//   busy       high in every state except IDLE
//   done       one-cycle pulse at the end of a sequence
// ----------------------------------------------------------------------------
module fetch_sequencer #(
    parameter int unsigned MEM_WAIT = 2
) (
    input  logic clock,
    input  logic reset,
    input  logic fetch_req,
    input  logic jump_req,
    output logic sel_pc,
    output logic sel_j,
    output logic sel_inc,
    output logic mem_read,
    output logic ld_inst,
    output logic ld_inc,
    output logic ld_pc,
    output logic busy,
    output logic done
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        F_ADDR  = 3'd1,
        F_READ  = 3'd2,
        F_LATCH = 3'd3,
        F_INC   = 3'd4,
        J_XFER  = 3'd5,
        DONE    = 3'd6
    } state_t;

    localparam logic [3:0] WAIT_LOAD = 4'(MEM_WAIT - 1);

    state_t     state;
    logic [3:0] wait_cnt;

    // State register and wait counter are the only storage; outputs below
    // are pure decodes of the state so requests never reach them directly.
    always_ff @(posedge clock) begin
        if (!reset) begin
            state    <= IDLE;
            wait_cnt <= '0;
        end else begin
            case (state)
                IDLE: begin
                    // Jump has priority; a simultaneous fetch is dropped.
                    if (jump_req) begin
                        state <= J_XFER;
                    end else if (fetch_req) begin
                        state <= F_ADDR;
                    end
                end
                F_ADDR: begin
                    wait_cnt <= WAIT_LOAD;
                    state    <= F_READ;
                end
                F_READ: begin
                    // Leaving on the zero count makes F_READ last MEM_WAIT cycles.
                    if (wait_cnt == '0) begin
                        state <= F_LATCH;
                    end else begin
                        wait_cnt <= wait_cnt - 4'd1;
                    end
                end
                F_LATCH: state <= F_INC;
                F_INC:   state <= DONE;
                J_XFER:  state <= DONE;
                DONE:    state <= IDLE;
                default: begin
                    state    <= IDLE;
                    wait_cnt <= '0;
                end
            endcase
        end
    end

    always_comb begin
        sel_pc   = 1'b0;
        sel_j    = 1'b0;
        sel_inc  = 1'b0;
        mem_read = 1'b0;
        ld_inst  = 1'b0;
        ld_inc   = 1'b0;
        ld_pc    = 1'b0;
        busy     = 1'b0;
        done     = 1'b0;
        case (state)
            F_ADDR: begin
                sel_pc = 1'b1;
                ld_inc = 1'b1;
                busy   = 1'b1;
            end
            F_READ: begin
                sel_pc   = 1'b1;
                mem_read = 1'b1;
                busy     = 1'b1;
            end
            F_LATCH: begin
                sel_pc   = 1'b1;
                mem_read = 1'b1;
                ld_inst  = 1'b1;
                busy     = 1'b1;
            end
            F_INC: begin
                sel_inc = 1'b1;
                ld_pc   = 1'b1;
                busy    = 1'b1;
            end
            J_XFER: begin
                sel_j = 1'b1;
                ld_pc = 1'b1;
                busy  = 1'b1;
            end
            DONE: begin
                done = 1'b1;
                busy = 1'b1;
            end
            default: ;
        endcase
    end

endmodule
